// File: rtl/conv2d_frame_sequencer.sv
// conv2d_frame_sequencer: sequences one N*N raster frame into a convolution datapath (clear, load, zero-pad flush, done)
module conv2d_frame_sequencer #(
  parameter int BIT_WIDTH = 17,
  parameter int INPUT_WIDTH = 8,
  parameter int PIPE_LATENCY = 5
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pix_in_valid,
  input  logic [BIT_WIDTH-1:0]           pix_in,
  output logic                           pix_in_ready,
  output logic                           conv_reset,
  output logic [BIT_WIDTH-1:0]           conv_pixel,
  output logic                           conv_pixel_valid,
  output logic [$clog2(INPUT_WIDTH)-1:0] row,
  output logic [$clog2(INPUT_WIDTH)-1:0] col,
  output logic                           busy,
  output logic                           frame_done,
  output logic [7:0]                     frame_count
);
  localparam int AW = $clog2(INPUT_WIDTH);
  localparam logic [AW-1:0] LAST = AW'(INPUT_WIDTH - 1);
  localparam int CW = $clog2(PIPE_LATENCY + 2);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DONE} state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic xfer, last_px;
  assign xfer = pix_in_ready & pix_in_valid;
  assign last_px = (row == LAST) && (col == LAST);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= next_state;
      cnt <= (next_state != state) ? '0 : cnt + 1'b1;
    end
  end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? CLEAR : IDLE;
      CLEAR:   next_state = (cnt == CW'(1)) ? LOAD : CLEAR;
      LOAD:    next_state = (xfer && last_px) ? FLUSH : LOAD;
      FLUSH:   next_state = (cnt == CW'(PIPE_LATENCY - 1)) ? DONE : FLUSH;
      DONE:    next_state = start ? CLEAR : IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_in_ready <= 1'b0;
      conv_pixel <= '0;
      conv_pixel_valid <= 1'b0;
      row <= '0;
      col <= '0;
      frame_count <= '0;
    end else begin
      pix_in_ready <= next_state == LOAD;
      conv_pixel_valid <= xfer || state == FLUSH;
      conv_pixel <= (state == FLUSH) ? '0 : xfer ? pix_in : conv_pixel;
      col <= (next_state == CLEAR) ? '0 : xfer ? ((col == LAST) ? '0 : col + 1'b1) : col;
      row <= (next_state == CLEAR) ? '0 : (xfer && col == LAST) ? ((row == LAST) ? '0 : row + 1'b1) : row;
      frame_count <= frame_count + 8'(next_state == DONE && state != DONE);
    end
  end
  always_comb begin
    conv_reset = reset || state == CLEAR;
    busy = state != IDLE;
    frame_done = state == DONE;
  end
endmodule

// File: doc/conv2d_frame_sequencer.md
CONV2D_FRAME_SEQUENCER -- requirements
Module: conv2d_frame_sequencer

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 Parameter BIT_WIDTH, default 17, SHALL set the pixel word width (signed fixed-point).
REQ-003 Parameter INPUT_WIDTH, default 8, SHALL set the square frame edge N; one frame is N*N pixels.
REQ-004 Parameter PIPE_LATENCY, default 5, SHALL set the drain cycles the convolution datapath needs after its last pixel.
REQ-005 Port clk, input, 1: system clock, all state updates on the rising edge.
REQ-006 Port reset, input, 1: asynchronous active-high reset.
REQ-007 Port start, input, 1: request to process one frame.
REQ-008 Port pix_in_valid, input, 1: upstream pixel valid.
REQ-009 Port pix_in, input, BIT_WIDTH: upstream pixel, raster order.
REQ-010 Port pix_in_ready, output, 1: sequencer accepts a pixel this cycle.
REQ-011 Port conv_reset, output, 1: reset to the convolution datapath.
REQ-012 Port conv_pixel, output, BIT_WIDTH: pixel presented to the datapath.
REQ-013 Port conv_pixel_valid, output, 1: datapath advance enable for conv_pixel.
REQ-014 Ports row and col, output, $clog2(N) each: raster position of the next pixel to be accepted.
REQ-015 Port busy, output, 1: a frame is in progress.
REQ-016 Port frame_done, output, 1: one-cycle pulse at frame completion.
REQ-017 Port frame_count, output, 8: completed-frame counter.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, LOAD, FLUSH and DONE, all encoded in registers.
REQ-019 In IDLE: busy=0 and pix_in_ready=0; start=1 at a rising edge -> CLEAR.
REQ-020 In CLEAR: conv_reset=1 for exactly 2 cycles, row=col=0 and busy=1, then -> LOAD.
REQ-021 In LOAD: pix_in_ready=1; a transfer occurs when pix_in_valid and pix_in_ready are both 1.
REQ-022 On a transfer, conv_pixel SHALL register pix_in and conv_pixel_valid SHALL be 1 in the next cycle.
REQ-023 In cycles with no transfer, conv_pixel_valid SHALL be 0 and conv_pixel SHALL hold its value (stall).
REQ-024 Raster counting: col increments on each transfer; at col=N-1 col wraps to 0 and row increments.
REQ-025 The N*N-th transfer (row=N-1, col=N-1) SHALL move the FSM to FLUSH, with row and col wrapping to 0.
REQ-026 In FLUSH: pix_in_ready=0, conv_pixel=0 and conv_pixel_valid=1 for exactly PIPE_LATENCY cycles (zero-padding drain), then -> DONE.
REQ-027 In DONE, for one cycle: frame_done=1, frame_count increments modulo 256 (255 -> 0), and busy=1.
REQ-028 From DONE: if start=1 -> CLEAR (back-to-back frame), else -> IDLE.
REQ-029 start SHALL be ignored in CLEAR, LOAD and FLUSH; no request is queued.
REQ-030 Latency: with pix_in_valid held at 1 and start sampled at cycle 0, pix_in_ready first SHALL be 1 at cycle 3, the last transfer SHALL occur at cycle 2+N*N, and frame_done SHALL be asserted at cycle 3+N*N+PIPE_LATENCY (72 for the defaults).
REQ-031 pix_in_ready SHALL be a registered, state-decoded signal with no combinational path from pix_in_valid.
REQ-032 conv_reset SHALL equal (state==CLEAR) OR reset, so the datapath is also cleared during a global reset.

Reset
REQ-033 While reset=1, regardless of clk: state=IDLE; pix_in_ready, conv_pixel_valid, busy and frame_done=0; conv_pixel, row, col and frame_count=0; conv_reset=1.
REQ-034 A reset asserted mid-frame SHALL abort the frame with no frame_done pulse and frame_count cleared to 0.
REQ-035 After reset deasserts, the block SHALL remain in IDLE until start is sampled.

Verification
REQ-036 Defaults, pix_in_valid=1, pix_in=0..63, start pulse at cycle 0 -> conv_reset high at cycles 1-2, 64 transfers at cycles 3-66 with conv_pixel following pix_in one cycle later, frame_done at cycle 72, frame_count=1.
REQ-037 Stall: pix_in_valid deasserted for 3 cycles after pixel 20 -> conv_pixel_valid=0 and conv_pixel=20 held for those cycles, row/col frozen at 2/5, frame_done delayed by 3 cycles to cycle 75.
REQ-038 Start held high continuously -> DONE goes directly to CLEAR, frames complete every 72 cycles, frame_count increments once per frame, no IDLE cycle between frames.
REQ-039 Async reset pulsed between clock edges at transfer 40 -> outputs zero immediately, conv_reset=1, no frame_done, frame_count=0; a following start completes a full frame normally.
REQ-040 Start pulses during LOAD and FLUSH -> ignored; exactly one frame_done; frame_count wraps 255 -> 0 after 256 frames (forced-count check).
